// File: rtl/word_packer.sv
// word_packer: gathers RATIO consecutive narrow words into one wide word.
// Valid/ready handshakes on both sides. One packed word is held in the
// output register while the next one assembles, so a continuous stream
// moves one narrow word per cycle.
// Optional feature macro: PACKER_FLUSH_EN enables the flush input, which
// pushes a partially filled word out (zero-filled, with out_count telling
// how many slots are valid). Without the macro the flush port is ignored.
module word_packer #(
  parameter int WORD_WIDTH_IN = 8,
  parameter int RATIO         = 4,
  parameter bit LSB_FIRST     = 1'b1,
  localparam int WORD_WIDTH_OUT = WORD_WIDTH_IN * RATIO,
  localparam int COUNT_WIDTH    = ($clog2(RATIO) < 1) ? 1 : $clog2(RATIO)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_WIDTH_IN-1:0]  in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_WIDTH_OUT-1:0] out_data,
  output logic [COUNT_WIDTH:0]      out_count
);

  localparam logic [COUNT_WIDTH-1:0] LAST_SLOT  = COUNT_WIDTH'(RATIO - 1);
  localparam logic [COUNT_WIDTH:0]   FULL_COUNT = (COUNT_WIDTH + 1)'(RATIO);

  // Map the running word count onto the physical slot it fills.
  function automatic logic [COUNT_WIDTH-1:0] slot_of(input logic [COUNT_WIDTH-1:0] cnt);
    logic [COUNT_WIDTH-1:0] slot;
    if (LSB_FIRST) begin
      slot = cnt;
    end else begin
      slot = LAST_SLOT - cnt;
    end
    return slot;
  endfunction

  // State registers
  logic [WORD_WIDTH_OUT-1:0] r_asm;
  logic [COUNT_WIDTH-1:0]    r_count;
  logic [WORD_WIDTH_OUT-1:0] r_out_data;
  logic [COUNT_WIDTH:0]      r_out_count;
  logic                      r_out_valid;
  logic                      r_in_ready;
  logic                      r_flush_pend;

  // Handshake and datapath helpers
  logic                      w_accept;
  logic                      w_consume;
  logic                      w_out_free;
  logic                      w_last;
  logic                      w_complete;
  logic [COUNT_WIDTH-1:0]    w_slot;
  logic [COUNT_WIDTH:0]      w_filled;
  logic [WORD_WIDTH_OUT-1:0] w_asm_merged;
  logic                      w_flush_go;
  logic                      w_flush_hold;

  // Next-state values
  logic [WORD_WIDTH_OUT-1:0] w_asm_nxt;
  logic [COUNT_WIDTH-1:0]    w_count_nxt;
  logic [WORD_WIDTH_OUT-1:0] w_out_data_nxt;
  logic [COUNT_WIDTH:0]      w_out_count_nxt;
  logic                      w_out_valid_nxt;
  logic                      w_in_ready_nxt;
  logic                      w_flush_pend_nxt;

  assign w_accept   = in_valid && r_in_ready;
  assign w_consume  = r_out_valid && out_ready;
  assign w_out_free = !r_out_valid || out_ready;
  assign w_last     = (r_count == LAST_SLOT);
  assign w_complete = w_accept && w_last;
  assign w_slot     = slot_of(r_count);

  // Number of slots holding data once this edge's word (if any) is in.
  always_comb begin
    if (w_accept) begin
      w_filled = {1'b0, r_count} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    end else begin
      w_filled = {1'b0, r_count};
    end
  end

  // Assembly word with the incoming narrow word dropped into its slot.
  always_comb begin
    w_asm_merged = r_asm;
    for (int k = 0; k < RATIO; k++) begin
      if (w_accept && (w_slot == COUNT_WIDTH'(k))) begin
        w_asm_merged[k*WORD_WIDTH_IN +: WORD_WIDTH_IN] = in_data;
      end else begin
        w_asm_merged[k*WORD_WIDTH_IN +: WORD_WIDTH_IN] = r_asm[k*WORD_WIDTH_IN +: WORD_WIDTH_IN];
      end
    end
  end

`ifdef PACKER_FLUSH_EN
  logic w_flush_req;

  // A flush is taken alongside an accepted word, or on its own while a
  // partial word exists; once taken it stays pending until the output
  // register can take the partial word.
  always_comb begin
    if (r_flush_pend) begin
      w_flush_req = 1'b1;
    end else if (flush && r_in_ready && (w_accept || (r_count != {COUNT_WIDTH{1'b0}}))) begin
      w_flush_req = 1'b1;
    end else begin
      w_flush_req = 1'b0;
    end
  end

  assign w_flush_go   = w_flush_req && !w_complete && w_out_free &&
                        (w_filled != {(COUNT_WIDTH + 1){1'b0}});
  assign w_flush_hold = w_flush_req && !w_complete && !w_out_free &&
                        (w_filled != {(COUNT_WIDTH + 1){1'b0}});
`else
  logic w_unused_flush;

  assign w_unused_flush = flush;
  assign w_flush_go     = 1'b0;
  assign w_flush_hold   = 1'b0;
`endif

  // Next-state selection: complete word, flushed partial word, drain, or hold.
  always_comb begin
    w_asm_nxt        = w_asm_merged;
    w_count_nxt      = w_filled[COUNT_WIDTH-1:0];
    w_out_data_nxt   = r_out_data;
    w_out_count_nxt  = r_out_count;
    w_out_valid_nxt  = r_out_valid;
    w_flush_pend_nxt = w_flush_hold;
    if (w_complete) begin
      w_out_data_nxt   = w_asm_merged;
      w_out_count_nxt  = FULL_COUNT;
      w_out_valid_nxt  = 1'b1;
      w_asm_nxt        = {WORD_WIDTH_OUT{1'b0}};
      w_count_nxt      = {COUNT_WIDTH{1'b0}};
      w_flush_pend_nxt = 1'b0;
    end else if (w_flush_go) begin
      w_out_data_nxt   = w_asm_merged;
      w_out_count_nxt  = w_filled;
      w_out_valid_nxt  = 1'b1;
      w_asm_nxt        = {WORD_WIDTH_OUT{1'b0}};
      w_count_nxt      = {COUNT_WIDTH{1'b0}};
      w_flush_pend_nxt = 1'b0;
    end else if (w_consume) begin
      w_out_valid_nxt  = 1'b0;
    end else begin
      w_out_valid_nxt  = r_out_valid;
    end
  end

  // Registered ready: stall only when the last slot is next and the output
  // register will still be occupied, or while a flush waits for space.
  always_comb begin
    if (w_flush_pend_nxt) begin
      w_in_ready_nxt = 1'b0;
    end else if (w_out_valid_nxt && (w_count_nxt == LAST_SLOT)) begin
      w_in_ready_nxt = 1'b0;
    end else begin
      w_in_ready_nxt = 1'b1;
    end
  end

  // State update with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_asm        <= {WORD_WIDTH_OUT{1'b0}};
      r_count      <= {COUNT_WIDTH{1'b0}};
      r_out_data   <= {WORD_WIDTH_OUT{1'b0}};
      r_out_count  <= {(COUNT_WIDTH + 1){1'b0}};
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_flush_pend <= 1'b0;
    end else begin
      r_asm        <= w_asm_nxt;
      r_count      <= w_count_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_count  <= w_out_count_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_in_ready   <= w_in_ready_nxt;
      r_flush_pend <= w_flush_pend_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

endmodule
